// File: rtl/button_press_classifier_pkg.sv
// Shared definitions for the button press classifier: state encoding, default timing constants.
// WAIT_2ND/SECOND exist only when DOUBLE_CLICK_EN is defined.
package button_press_classifier_pkg;

  localparam int DEF_CLK_HZ  = 100_000_000;
  localparam int DEF_TICK_HZ = 1000;
  localparam int DEF_LONG_MS = 1000;
  localparam int DEF_DBL_MS  = 300;
  localparam int DEF_CNT_W   = 8;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PRESSED   = 3'd1,
    S_LONG_HELD = 3'd2
`ifdef DOUBLE_CLICK_EN
    ,
    S_WAIT_2ND  = 3'd3,
    S_SECOND    = 3'd4
`endif
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_press_classifier_tick_gen.sv
// Free-running prescaler: registered one-cycle tick every CLK_HZ/TICK_HZ clocks.
module button_press_classifier_tick_gen #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 1000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == LAST) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/button_press_classifier.sv
// Classifies debounced button presses into short/long (and double with DOUBLE_CLICK_EN) pulses.
// Handshake-free: clean is a level, all outputs are registered and pulses are one cycle wide.
module button_press_classifier
  import button_press_classifier_pkg::*;
#(
  parameter int CLK_HZ  = DEF_CLK_HZ,
  parameter int TICK_HZ = DEF_TICK_HZ,
  parameter int LONG_MS = DEF_LONG_MS,
  parameter int DBL_MS  = DEF_DBL_MS,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clean,
  output logic             short_pulse,
  output logic             long_pulse,
  output logic             double_pulse,
  output logic             held,
  output logic [CNT_W-1:0] press_cnt,
  output logic             busy,
  output logic [2:0]       dbg_state
);

  localparam int TMAX = max_int(LONG_MS, DBL_MS);
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] T_LONG = TW'(LONG_MS);
  localparam logic [TW-1:0] T_MAX  = TW'(TMAX);
`ifdef DOUBLE_CLICK_EN
  localparam logic [TW-1:0] T_DBL  = TW'(DBL_MS);
`endif

  state_t        state, state_nxt;
  logic [TW-1:0] timer;
  logic          clean_q, tick, rise, fall;
  logic          short_nxt, long_nxt, double_nxt, held_nxt;

  button_press_classifier_tick_gen #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign rise      = clean & ~clean_q;
  assign fall      = ~clean & clean_q;
  assign dbg_state = state;

  always_comb begin
    state_nxt  = state;
    short_nxt  = 1'b0;
    long_nxt   = 1'b0;
    double_nxt = 1'b0;
    held_nxt   = held;
    case (state)
      S_IDLE: if (rise) state_nxt = S_PRESSED;
      S_PRESSED: begin
        // Timeout beats a coincident release: report long, skip the held phase.
        if (timer == T_LONG) begin
          long_nxt = 1'b1;
          if (fall) begin
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_LONG_HELD;
            held_nxt  = 1'b1;
          end
        end else if (fall) begin
`ifdef DOUBLE_CLICK_EN
          state_nxt = S_WAIT_2ND;
`else
          short_nxt = 1'b1;
          state_nxt = S_IDLE;
`endif
        end
      end
      S_LONG_HELD: begin
        if (fall) begin
          held_nxt  = 1'b0;
          state_nxt = S_IDLE;
        end
      end
`ifdef DOUBLE_CLICK_EN
      S_WAIT_2ND: begin
        if (rise) begin
          double_nxt = 1'b1;
          state_nxt  = S_SECOND;
        end else if (timer == T_DBL) begin
          short_nxt = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_SECOND: if (fall) state_nxt = S_IDLE;
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      timer       <= '0;
      clean_q     <= 1'b0;
      short_pulse <= 1'b0;
      long_pulse  <= 1'b0;
      held        <= 1'b0;
      press_cnt   <= '0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      clean_q     <= clean;
      short_pulse <= short_nxt;
      long_pulse  <= long_nxt;
      held        <= held_nxt;
      busy        <= (state_nxt != S_IDLE);
      if (rise) press_cnt <= press_cnt + 1'b1;
      // Each state measures its own interval, so any transition restarts the timer.
      if (state_nxt != state)             timer <= '0;
      else if (tick && (timer != T_MAX))  timer <= timer + 1'b1;
    end
  end

`ifdef DOUBLE_CLICK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) double_pulse <= 1'b0;
    else        double_pulse <= double_nxt;
  end
`else
  logic unused_double;
  assign unused_double = double_nxt;
  assign double_pulse  = 1'b0;
`endif

endmodule
